// File: rtl/bin_para_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_para_bcd_pkg
//  Description : Shared definitions for the binary-to-BCD converter.
//                - c_BLANK_CODE : digit code the display decoder draws as
//                                 all segments off
//                - estado_t     : converter FSM state type and encodings
//                - largura_contador : bit-counter width, clog2(n+1)
//  Revision    : 1.0 - initial release
// ============================================================================
package bin_para_bcd_pkg;

   localparam logic [3:0] c_BLANK_CODE = 4'hF;

   localparam int c_ESTADO_W = 2;
   typedef logic [c_ESTADO_W-1:0] estado_t;

   localparam estado_t c_OCIOSO  = 2'd0;   // waiting for a start request
   localparam estado_t c_DESLOCA = 2'd1;   // one shift-and-add-3 step per clock
   localparam estado_t c_CONCLUI = 2'd2;   // result published, ready pulse

   // Number of bits needed to hold the value n, which is clog2(n+1).
   function automatic int largura_contador(input int n);
      int w;
      w = 1;
      while ((2 ** w) <= n) w++;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin_para_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_para_bcd_if
//  Description : Start/result handshake of the binary-to-BCD converter.
//                inicio  : start request (master -> slave)
//                binario : value to convert, LARGURA bits (master -> slave)
//                ocupado : conversion in progress (slave -> master)
//                pronto  : one-cycle pulse, digitos just updated
//                digitos : packed BCD, digit 0 in [3:0] (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_para_bcd_if #(
   parameter int LARGURA = 8,
   parameter int DIGITOS = 3
) ();

   logic                   inicio;
   logic [LARGURA-1:0]     binario;
   logic                   ocupado;
   logic                   pronto;
   logic [4*DIGITOS-1:0]   digitos;

   modport master (
      output inicio,
      output binario,
      input  ocupado,
      input  pronto,
      input  digitos
   );

   modport slave (
      input  inicio,
      input  binario,
      output ocupado,
      output pronto,
      output digitos
   );

endinterface
`default_nettype wire

// File: rtl/bin_para_bcd_ajuste.sv
`default_nettype none
// ============================================================================
//  Module      : bin_para_bcd_ajuste
//  Description : Combinational double-dabble cell: a BCD digit of 5 or more
//                gets +3 so that the following left shift carries correctly.
//                i_digito : current BCD digit
//                o_digito : adjusted digit, ready to be shifted
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_para_bcd_ajuste (
   input  wire logic [3:0] i_digito,
   output logic      [3:0] o_digito
);

   always_comb begin
      o_digito = i_digito;
      if (i_digito >= 4'd5) o_digito = i_digito + 4'd3;
   end

endmodule
`default_nettype wire

// File: rtl/bin_para_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin_para_bcd
//  Description : Sequential binary-to-BCD converter (shift-and-add-3, one
//                input bit per clock). A start accepted while idle captures
//                binario; LARGURA shift cycles later digitos is updated and
//                pronto pulses for one cycle. Values of 10^DIGITOS or more
//                wrap to their low DIGITOS decimal digits.
//  Ports       : clk  - rising-edge system clock
//                rst  - synchronous, active-high reset (aborts conversion,
//                       clears digitos)
//                bus  - bin_para_bcd_if.slave (inicio, binario, ocupado,
//                       pronto, digitos)
//  Config      : ZERO_BLANK_EN - when defined, leading zero digits of the
//                published result (never digit 0) show c_BLANK_CODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_para_bcd
   import bin_para_bcd_pkg::*;
#(
   parameter int LARGURA = 8,
   parameter int DIGITOS = 3
) (
   input wire logic           clk,
   input wire logic           rst,
   bin_para_bcd_if.slave      bus
);

   localparam int c_CONT_W = largura_contador(LARGURA);
   localparam int c_BCD_W  = 4 * DIGITOS;

   estado_t                     r_estado;
   estado_t                     w_prox;
   logic [LARGURA-1:0]          r_bin;
   logic [c_BCD_W-1:0]          r_bcd;
   logic [c_CONT_W-1:0]         r_cont;
   logic [c_BCD_W-1:0]          r_digitos;
   logic [c_BCD_W-1:0]          w_ajust;
   logic [c_BCD_W+LARGURA-1:0]  w_deslocado;
   logic [c_BCD_W-1:0]          w_bcd_prox;
   logic [LARGURA-1:0]          w_bin_prox;
   logic [c_BCD_W-1:0]          w_digitos_fmt;
   logic                        w_ultimo;

   // Add-3 correction on every digit before the shift.
   for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
      bin_para_bcd_ajuste u_ajuste (
         .i_digito (r_bcd[4*g +: 4]),
         .o_digito (w_ajust[4*g +: 4])
      );
   end

   // Shift {bcd,bin} left as one word; the bit leaving the top digit is the
   // natural mod 10^DIGITOS truncation (lower digits never depend on it).
   assign w_deslocado = {w_ajust, r_bin} << 1;
   assign w_bcd_prox  = w_deslocado[c_BCD_W+LARGURA-1 -: c_BCD_W];
   assign w_bin_prox  = w_deslocado[LARGURA-1:0];
   assign w_ultimo    = (r_cont == c_CONT_W'(1));

`ifdef ZERO_BLANK_EN
   logic w_lider;

   // Blank zeros from the top digit down to the first nonzero one; digit 0
   // always shows a numeral.
   always_comb begin
      w_digitos_fmt = w_bcd_prox;
      w_lider       = 1'b1;
      for (int i = DIGITOS - 1; i >= 1; i--) begin
         if (w_lider && (w_bcd_prox[4*i +: 4] == 4'd0)) begin
            w_digitos_fmt[4*i +: 4] = c_BLANK_CODE;
         end else begin
            w_lider = 1'b0;
         end
      end
   end
`else
   assign w_digitos_fmt = w_bcd_prox;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_estado <= c_OCIOSO;
      else     r_estado <= w_prox;
   end

   // Next-state logic
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         c_OCIOSO:  if (bus.inicio) w_prox = c_DESLOCA;
         c_DESLOCA: if (w_ultimo)   w_prox = c_CONCLUI;
         c_CONCLUI: w_prox = c_OCIOSO;
         default:   w_prox = c_OCIOSO;
      endcase
   end

   // Outputs
   always_comb begin
      bus.ocupado = (r_estado != c_OCIOSO);
      bus.pronto  = (r_estado == c_CONCLUI);
      bus.digitos = r_digitos;
   end

   // Datapath. The result register is written on the edge that enters
   // CONCLUI so that digitos is already valid during the pronto cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cont    <= '0;
         r_digitos <= '0;
      end else begin
         case (r_estado)
            c_OCIOSO: begin
               if (bus.inicio) begin
                  r_bin  <= bus.binario;
                  r_bcd  <= '0;
                  r_cont <= c_CONT_W'(LARGURA);
               end
            end
            c_DESLOCA: begin
               r_bin  <= w_bin_prox;
               r_bcd  <= w_bcd_prox;
               r_cont <= r_cont - c_CONT_W'(1);
               if (w_ultimo) r_digitos <= w_digitos_fmt;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin_para_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_para_bcd
//  Description : Self-checking bench for bin_para_bcd. dut1 uses LARGURA=8,
//                DIGITOS=3; dut2 uses LARGURA=10, DIGITOS=2. A decimal model
//                plus a busy-cycle countdown predicts dut1 outputs on every
//                cycle; directed vectors carry hand-computed literals.
//  Config      : ZERO_BLANK_EN selects the blanked expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_para_bcd;

   localparam int L1 = 8;
   localparam int D1 = 3;
   localparam int L2 = 10;
   localparam int D2 = 2;

`ifdef ZERO_BLANK_EN
   localparam logic [11:0] E_0   = 12'hFF0;
   localparam logic [11:0] E_9   = 12'hFF9;
   localparam logic [11:0] E_42  = 12'hF42;
   localparam logic [7:0]  E2_305 = 8'hF5;
`else
   localparam logic [11:0] E_0   = 12'h000;
   localparam logic [11:0] E_9   = 12'h009;
   localparam logic [11:0] E_42  = 12'h042;
   localparam logic [7:0]  E2_305 = 8'h05;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bin_para_bcd_if #(.LARGURA(L1), .DIGITOS(D1)) bus1 ();
   bin_para_bcd_if #(.LARGURA(L2), .DIGITOS(D2)) bus2 ();

   bin_para_bcd #(.LARGURA(L1), .DIGITOS(D1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   bin_para_bcd #(.LARGURA(L2), .DIGITOS(D2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, got, exp, $time);
      end
   endtask

   // Decimal reference: value mod 10^d, digit by digit, optional blanking of
   // the positions above the number's significant digits.
   function automatic logic [11:0] modelo(input int v, input int d);
      int p;
      int r;
      int q;
      int sig;
      logic [11:0] res;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      r   = v % p;
      q   = r;
      res = '0;
      for (int i = 0; i < d; i++) begin
         res[4*i +: 4] = 4'(q % 10);
         q = q / 10;
      end
      sig = 1;
      for (int t = r; t >= 10; t = t / 10) sig++;
`ifdef ZERO_BLANK_EN
      for (int i = sig; i < d; i++) res[4*i +: 4] = 4'hF;
`endif
      return res;
   endfunction

   // Cycle model for dut1: m_rest counts the busy cycles left (LARGURA+1
   // after acceptance); the result appears when one busy cycle remains.
   int          m_rest = 0;
   int          m_val  = 0;
   logic [11:0] m_dig  = '0;
   bit          chk_on = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_rest <= 0;
         m_dig  <= '0;
      end else if (m_rest == 0) begin
         if (bus1.inicio) begin
            m_rest <= L1 + 1;
            m_val  <= int'(bus1.binario);
         end
      end else begin
         m_rest <= m_rest - 1;
         if (m_rest == 2) m_dig <= modelo(m_val, D1);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("mon_ocupado", 32'(bus1.ocupado), 32'(m_rest > 0));
         chk("mon_pronto",  32'(bus1.pronto),  32'(m_rest == 1));
         chk("mon_digitos", 32'(bus1.digitos), 32'(m_dig));
      end
   end

   // Counts sampled cycles until pronto (bounded); lat=1 is the first cycle
   // after the accepting edge.
   task automatic esperar1(output logic [11:0] res, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus1.pronto) break;
      end
      res = bus1.digitos;
   endtask

   task automatic conv1(input int val, output logic [11:0] res, output int lat);
      @(posedge clk); #1;
      bus1.binario = 8'(val);
      bus1.inicio  = 1'b1;
      @(posedge clk); #1;
      bus1.inicio  = 1'b0;
      esperar1(res, lat);
   endtask

   task automatic conv2(input int val, output logic [7:0] res, output int lat);
      @(posedge clk); #1;
      bus2.binario = 10'(val);
      bus2.inicio  = 1'b1;
      @(posedge clk); #1;
      bus2.inicio  = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus2.pronto) break;
      end
      res = bus2.digitos;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] res;
      logic [7:0]  res2;
      int          lat;
      int          npr;

      rst          = 1'b1;
      bus1.inicio  = 1'b0;
      bus1.binario = '0;
      bus2.inicio  = 1'b0;
      bus2.binario = '0;
      @(posedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst_ocupado", 32'(bus1.ocupado), 32'd0);
      chk("rst_pronto",  32'(bus1.pronto),  32'd0);
      chk("rst_digitos", 32'(bus1.digitos), 32'd0);
      chk("rst_digitos2", 32'(bus2.digitos), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: 255, latency 9
      conv1(255, res, lat);
      chk("t1_lat", 32'(lat), 32'd9);
      chk("t1_val", 32'(res), 32'h255);

      // 2: zero
      conv1(0, res, lat);
      chk("t2_val", 32'(res), 32'(E_0));

      // 3: 9 then 100, second start raised during the pronto cycle
      conv1(9, res, lat);
      chk("t3a_val", 32'(res), 32'(E_9));
      bus1.binario = 8'd100;
      bus1.inicio  = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      bus1.inicio  = 1'b0;
      esperar1(res, lat);
      chk("t3b_lat", 32'(lat), 32'd9);
      chk("t3b_val", 32'(res), 32'h100);

      // 4: start and new binario held high while busy with 200
      @(posedge clk); #1;
      bus1.binario = 8'd200;
      bus1.inicio  = 1'b1;
      @(posedge clk); #1;
      bus1.binario = 8'd7;
      esperar1(res, lat);
      bus1.inicio  = 1'b0;
      chk("t4_lat", 32'(lat), 32'd9);
      chk("t4_val", 32'(res), 32'h200);
      repeat (3) @(negedge clk);
      chk("t4_idle", 32'(bus1.ocupado), 32'd0);
      chk("t4_hold", 32'(bus1.digitos), 32'h200);

      // 5: reset during cycle 4 of a conversion
      @(posedge clk); #1;
      bus1.binario = 8'd255;
      bus1.inicio  = 1'b1;
      @(posedge clk); #1;
      bus1.inicio  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_ocupado", 32'(bus1.ocupado), 32'd0);
      chk("t5_digitos", 32'(bus1.digitos), 32'd0);
      npr = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus1.pronto) npr++;
      end
      chk("t5_no_pronto", 32'(npr), 32'd0);
      conv1(42, res, lat);
      chk("t5_val", 32'(res), 32'(E_42));

      // 6: LARGURA=10, DIGITOS=2
      conv2(1023, res2, lat);
      chk("t6_lat", 32'(lat), 32'd11);
      chk("t6_val", 32'(res2), 32'h23);
      conv2(305, res2, lat);
      chk("t6_305", 32'(res2), 32'(E2_305));
      conv2(999, res2, lat);
      chk("t6_999", 32'(res2), 32'h99);

      // Sweep 0..255
      for (int v = 0; v < 256; v++) begin
         conv1(v, res, lat);
         chk("sweep", 32'(res), 32'(modelo(v, D1)));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
